traceback_ctrl: RTL and testbench
=================================

# traceback_ctrl

Traceback controller sitting directly downstream of the score RAM in the Needleman-Wunsch datapath. After the fill engine has written the (N+1)x(N+1) score matrix, it walks from cell (len_a, len_b) back to (0,0) through the RAM read port. At each step it emits one alignment direction on a valid/ready stream, so the alignment builder can reconstruct the aligned strings.

## Interface
- N, 128, maximum sequence length; the matrix is (N+1)x(N+1), row-major, address = i*(N+1)+j.
- ADDR_W, $clog2((N+1)*(N+1)), RAM address width.
- LEN_W, $clog2(N+1), length width.
- GAP, -2, signed gap penalty used by the fill engine.

- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  one-cycle request; sampled only in IDLE.
- len_a  in  LEN_W  rows used (sequence A length); sampled with start.
- len_b  in  LEN_W  columns used (sequence B length); sampled with start.
- en_dout  out  1  RAM read enable.
- addr_dout  out  ADDR_W  RAM read address.
- dout  in  9  signed RAM read data, registered; valid the cycle after en_dout.
- dir  out  2  direction: 00 DIAG, 01 UP, 10 LEFT.
- dir_valid  out  1  dir beat valid.
- dir_ready  in  1  consumer accepts beat.
- dir_last  out  1  beat ends at (0,0).
- busy  out  1  high from the cycle after start until FINISH exits.
- done  out  1  one-cycle pulse in FINISH.
- final_score  out  9  signed score of (len_a,len_b), held until next start.

## Operation
- Registers: i, j (LEN_W); row_base = i*(N+1) (ADDR_W), updated incrementally by subtracting N+1; cur, up (9-bit signed).
- IDLE: on start, load i=len_a, j=len_b, row_base=len_a*(N+1), go to RD_CUR. While not in IDLE, start is ignored.
- RD_CUR: en_dout=1, addr=row_base+j, go to RD_UP.
- RD_UP:
  - Latch cur=dout; on the first step only, also latch final_score.
  - If i==0 and j==0, go to FINISH.
  - If i==0, dir=LEFT and go to EMIT.
  - If j==0, dir=UP and go to EMIT.
  - Otherwise en_dout=1, addr=row_base-(N+1)+j, go to RD_LEFT.
- RD_LEFT: latch up=dout; en_dout=1, addr=row_base+j-1; go to DECIDE.
- DECIDE: left=dout. Priority order:
  - If cur==up+GAP, dir=UP.
  - Else if cur==left+GAP, dir=LEFT.
  - Else dir=DIAG.
  - Go to EMIT.
- Arithmetic: sums are computed sign-extended to 10 bits; no saturation.
- EMIT: dir_valid=1. dir_last is high when the move lands on (0,0). On dir_ready:
  - UP: i--, row_base-=N+1.
  - LEFT: j--.
  - DIAG: both.
  - Go to FINISH if dir_last, else RD_CUR.
- FINISH: done=1, go to IDLE.
- en_dout is low in every state not listed as asserting it; addr_dout holds its last value.

## Timing
- Reset values: en_dout 0, addr_dout 0, dir 00, dir_valid 0, dir_last 0, busy 0, done 0, final_score 0. State returns to IDLE.
- Reset mid-operation aborts the walk; a partially emitted path is discarded by the consumer.
- Read latency is 1 cycle: an address issued in cycle t is consumed as dout in cycle t+1.
- Interior step: 5 cycles with dir_ready held high (RD_CUR, RD_UP, RD_LEFT, DECIDE, EMIT).
- Boundary step (i==0 or j==0): 3 cycles.
- Handshake:
  - dir, dir_last and dir_valid are stable while dir_valid && !dir_ready.
  - No RAM reads are issued during a stall.
  - A beat transfers on any cycle with dir_valid && dir_ready.
- A path has at most len_a+len_b beats; exactly one beat carries dir_last.
- len_a=len_b=0: no beats are emitted; final_score=ram[0]; done pulses 3 cycles after start.

## Configuration
- TRACEBACK_PATHLEN_EN:
  - Defined: adds output path_len (LEN_W+1 bits). It resets to 0, clears on accepted start, increments on each transferred beat, and holds after done.
  - Undefined: the port and counter are absent; all other behaviour is identical.

## Test plan
- N=4, len_a=len_b=0, ram[0]=0: start -> no dir_valid; final_score=0; done in cycle start+3; busy low afterwards.
- len_a=2, len_b=0, column scores 0,-2,-4 -> two UP beats, second with dir_last; final_score=-4; read addresses 10 then 5.
- len_a=len_b=1; H(1,1)=1, H(0,1)=-2, H(1,0)=-2, H(0,0)=0 -> single DIAG beat with dir_last; final_score=1.
- Tie: H(1,1)=-4, H(0,1)=-2, H(1,0)=-2 -> UP chosen, then LEFT with dir_last.
- Backpressure: dir_ready low for 3 cycles in EMIT -> dir and dir_valid held; en_dout stays 0; the beat transfers on the first ready cycle.
- rst asserted during EMIT -> all outputs at reset values next cycle. A start pulse while busy is ignored; a fresh start after reset walks correctly.

Source files
------------

// File: rtl/traceback_ctrl.sv
// traceback_ctrl: walks the Needleman-Wunsch score matrix from (len_a,len_b) back to (0,0),
// emitting one move per valid/ready beat. Define TRACEBACK_PATHLEN_EN to add the path_len output.
module traceback_ctrl #(
    parameter int N      = 128,
    parameter int ADDR_W = $clog2((N+1)*(N+1)),
    parameter int LEN_W  = $clog2(N+1),
    parameter int GAP    = -2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [LEN_W-1:0]   len_a,
    input  logic [LEN_W-1:0]   len_b,
    output logic               en_dout,
    output logic [ADDR_W-1:0]  addr_dout,
    input  logic signed [8:0]  dout,
    output logic [1:0]         dir,
    output logic               dir_valid,
    input  logic               dir_ready,
    output logic               dir_last,
    output logic               busy,
    output logic               done,
    output logic signed [8:0]  final_score
`ifdef TRACEBACK_PATHLEN_EN
    ,output logic [LEN_W:0]    path_len
`endif
);

    typedef enum logic [2:0] {IDLE, RD_CUR, RD_UP, RD_LEFT, DECIDE, EMIT, FINISH} state_t;

    localparam logic [1:0]        DIAG   = 2'b00;
    localparam logic [1:0]        UP     = 2'b01;
    localparam logic [1:0]        LEFT   = 2'b10;
    localparam logic [ADDR_W-1:0] STRIDE = ADDR_W'(N+1);
    localparam logic signed [9:0] GAP10  = 10'(GAP);

    state_t             state_q;
    logic [LEN_W-1:0]   i_q, j_q;
    logic [ADDR_W-1:0]  row_base_q, addr_q;
    logic signed [8:0]  cur_q, up_q, final_q;
    logic               first_q, en_q, valid_q, last_q, busy_q, done_q;
    logic [1:0]         dir_q;
`ifdef TRACEBACK_PATHLEN_EN
    logic [LEN_W:0]     plen_q;
`endif

    // Outputs are registered, so read addresses are computed one state early.
    logic [ADDR_W-1:0]  start_base, up_addr, left_addr;
    logic signed [9:0]  cur10, up_sum, left_sum;
    logic [1:0]         dec_dir;
    logic               dec_last, step_row, step_col;
    logic [ADDR_W-1:0]  nb_d;
    logic [LEN_W-1:0]   ni_d, nj_d;

    always_comb begin
        start_base = ADDR_W'(len_a) * STRIDE;
        up_addr    = row_base_q - STRIDE + ADDR_W'(j_q);
        left_addr  = row_base_q + ADDR_W'(j_q) - ADDR_W'(1);
        cur10      = {cur_q[8], cur_q};
        up_sum     = {up_q[8], up_q} + GAP10;
        left_sum   = {dout[8], dout} + GAP10;
        if (cur10 == up_sum)        dec_dir = UP;
        else if (cur10 == left_sum) dec_dir = LEFT;
        else                        dec_dir = DIAG;
        // Interior cells have i,j >= 1, so only a diagonal move can land on the origin.
        dec_last = (dec_dir == DIAG) && (i_q == LEN_W'(1)) && (j_q == LEN_W'(1));
        step_row = (dir_q != LEFT);
        step_col = (dir_q != UP);
        nb_d     = step_row ? row_base_q - STRIDE : row_base_q;
        ni_d     = step_row ? i_q - LEN_W'(1) : i_q;
        nj_d     = step_col ? j_q - LEN_W'(1) : j_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            i_q        <= '0;
            j_q        <= '0;
            row_base_q <= '0;
            addr_q     <= '0;
            cur_q      <= '0;
            up_q       <= '0;
            final_q    <= '0;
            first_q    <= 1'b0;
            en_q       <= 1'b0;
            valid_q    <= 1'b0;
            last_q     <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            dir_q      <= DIAG;
`ifdef TRACEBACK_PATHLEN_EN
            plen_q     <= '0;
`endif
        end else begin
            en_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        i_q        <= len_a;
                        j_q        <= len_b;
                        row_base_q <= start_base;
                        en_q       <= 1'b1;
                        addr_q     <= start_base + ADDR_W'(len_b);
                        busy_q     <= 1'b1;
                        first_q    <= 1'b1;
                        state_q    <= RD_CUR;
`ifdef TRACEBACK_PATHLEN_EN
                        plen_q     <= '0;
`endif
                    end
                end
                RD_CUR: begin
                    state_q <= RD_UP;
                    if (i_q != '0 && j_q != '0) begin
                        en_q   <= 1'b1;
                        addr_q <= up_addr;
                    end
                end
                RD_UP: begin
                    cur_q <= dout;
                    if (first_q) begin
                        final_q <= dout;
                        first_q <= 1'b0;
                    end
                    if (i_q == '0 && j_q == '0) begin
                        done_q  <= 1'b1;
                        state_q <= FINISH;
                    end else if (i_q == '0) begin
                        dir_q   <= LEFT;
                        last_q  <= (j_q == LEN_W'(1));
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end else if (j_q == '0) begin
                        dir_q   <= UP;
                        last_q  <= (i_q == LEN_W'(1));
                        valid_q <= 1'b1;
                        state_q <= EMIT;
                    end else begin
                        en_q    <= 1'b1;
                        addr_q  <= left_addr;
                        state_q <= RD_LEFT;
                    end
                end
                RD_LEFT: begin
                    up_q    <= dout;
                    state_q <= DECIDE;
                end
                DECIDE: begin
                    dir_q   <= dec_dir;
                    last_q  <= dec_last;
                    valid_q <= 1'b1;
                    state_q <= EMIT;
                end
                EMIT: begin
                    if (dir_ready) begin
                        valid_q    <= 1'b0;
                        last_q     <= 1'b0;
                        i_q        <= ni_d;
                        j_q        <= nj_d;
                        row_base_q <= nb_d;
`ifdef TRACEBACK_PATHLEN_EN
                        plen_q     <= plen_q + 1'b1;
`endif
                        if (last_q) begin
                            done_q  <= 1'b1;
                            state_q <= FINISH;
                        end else begin
                            en_q    <= 1'b1;
                            addr_q  <= nb_d + ADDR_W'(nj_d);
                            state_q <= RD_CUR;
                        end
                    end
                end
                FINISH: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign en_dout     = en_q;
    assign addr_dout   = addr_q;
    assign dir         = dir_q;
    assign dir_valid   = valid_q;
    assign dir_last    = last_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign final_score = final_q;
`ifdef TRACEBACK_PATHLEN_EN
    assign path_len    = plen_q;
`endif

endmodule

// File: tb/tb_traceback_ctrl.sv
// Directed bench for traceback_ctrl with N=4 and a 1-cycle registered RAM model.
module tb_traceback_ctrl;

    localparam int N  = 4;
    localparam int AW = 5;
    localparam int LW = 3;

    logic                 clk = 1'b0;
    logic                 rst, start, dir_ready;
    logic [LW-1:0]        len_a, len_b;
    logic                 en_dout;
    logic [AW-1:0]        addr_dout;
    logic signed [8:0]    dout;
    logic [1:0]           dir;
    logic                 dir_valid, dir_last, busy, done;
    logic signed [8:0]    final_score;
`ifdef TRACEBACK_PATHLEN_EN
    logic [LW:0]          path_len;
`endif

    traceback_ctrl #(.N(N)) dut (
        .clk(clk), .rst(rst), .start(start), .len_a(len_a), .len_b(len_b),
        .en_dout(en_dout), .addr_dout(addr_dout), .dout(dout),
        .dir(dir), .dir_valid(dir_valid), .dir_ready(dir_ready), .dir_last(dir_last),
        .busy(busy), .done(done), .final_score(final_score)
`ifdef TRACEBACK_PATHLEN_EN
        , .path_len(path_len)
`endif
    );

    always #5 clk = ~clk;

    logic signed [8:0] ram [0:24];
    always @(posedge clk) if (en_dout) dout <= ram[addr_dout];

    typedef struct {
        logic [LW-1:0]     la, lb;
        logic signed [8:0] h00, h01, h02, h10, h11, h20;
        int                nbeats;
        int                d0, d1;
        logic signed [8:0] fin;
        int                done_cyc;
    } vec_t;

    vec_t tbl [8];
    int   errors = 0;
    int   checks = 0;
    int   beats, done_cyc;
    int   bd [4];
    int   bl [4];
    int   addr_log [$];

    function automatic vec_t mk(int la, int lb, int h00, int h01, int h02, int h10, int h11,
                                int h20, int nb, int d0, int d1, int fin, int dc);
        vec_t v;
        v.la = LW'(la);   v.lb = LW'(lb);
        v.h00 = 9'(h00);  v.h01 = 9'(h01); v.h02 = 9'(h02);
        v.h10 = 9'(h10);  v.h11 = 9'(h11); v.h20 = 9'(h20);
        v.nbeats = nb;    v.d0 = d0;       v.d1 = d1;
        v.fin = 9'(fin);  v.done_cyc = dc;
        return v;
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_ram(input vec_t v);
        for (int a = 0; a < 25; a++) ram[a] = 9'sd100;
        ram[0] = v.h00; ram[1] = v.h01; ram[2] = v.h02;
        ram[5] = v.h10; ram[6] = v.h11; ram[10] = v.h20;
    endtask

    // Runs a walk with dir_ready high; optionally pulses a bogus start while busy.
    task automatic run_walk(input vec_t v, input bit glitch);
        int cyc;
        load_ram(v);
        beats = 0;
        done_cyc = -1;
        addr_log.delete();
        len_a = v.la; len_b = v.lb; dir_ready = 1'b1; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        chk("busy_first_cycle", int'(busy), 1);
        while (cyc <= 60) begin
            if (en_dout) addr_log.push_back(int'(addr_dout));
            if (dir_valid && dir_ready) begin
                if (beats < 4) begin
                    bd[beats] = int'(dir);
                    bl[beats] = int'(dir_last);
                end
                beats++;
            end
            if (done) begin
                done_cyc = cyc;
                break;
            end
            if (glitch && cyc == 2) begin
                start = 1'b1; len_a = '0; len_b = '0;
            end else begin
                start = 1'b0;
            end
            tick();
            cyc++;
        end
        start = 1'b0;
        if (done_cyc < 0) chk("walk_timeout", 0, 1);
        tick();
        chk("busy_after_done", int'(busy), 0);
        chk("done_one_cycle", int'(done), 0);
    endtask

    task automatic check_walk(input vec_t v, input int idx);
        chk($sformatf("v%0d_done_cycle", idx), done_cyc, v.done_cyc);
        chk($sformatf("v%0d_beats", idx), beats, v.nbeats);
        chk($sformatf("v%0d_final", idx), int'(final_score), int'(v.fin));
        for (int k = 0; k < v.nbeats && k < 2; k++) begin
            chk($sformatf("v%0d_dir%0d", idx, k), bd[k], (k == 0) ? v.d0 : v.d1);
            chk($sformatf("v%0d_last%0d", idx, k), bl[k], (k == v.nbeats - 1) ? 1 : 0);
        end
`ifdef TRACEBACK_PATHLEN_EN
        chk($sformatf("v%0d_path_len", idx), int'(path_len), v.nbeats);
`endif
    endtask

    task automatic wait_valid(output bit ok);
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (dir_valid) begin
                ok = 1'b1;
                break;
            end
            tick();
        end
        if (!ok) chk("wait_valid_timeout", 0, 1);
    endtask

    initial begin
        bit ok;
        //              la lb h00  h01  h02 h10 h11  h20 nb d0 d1 fin  dc
        tbl[0] = mk(0, 0,   0, 100, 100, 100, 100, 100, 0, 0, 0,   0, 3);
        tbl[1] = mk(2, 0,   0, 100, 100,  -2, 100,  -4, 2, 1, 1,  -4, 7);
        tbl[2] = mk(1, 1,   0,  -2, 100,  -2,   1, 100, 1, 0, 0,   1, 6);
        tbl[3] = mk(1, 1,   0,  -2, 100,  -2,  -4, 100, 2, 1, 2,  -4, 9);
        tbl[4] = mk(1, 1,   0,   5, 100,  -2,  -4, 100, 2, 2, 1,  -4, 9);
        tbl[5] = mk(0, 2,   0,  -2,  -4, 100, 100, 100, 2, 2, 2,  -4, 7);
        tbl[6] = mk(0, 0,  -7, 100, 100, 100, 100, 100, 0, 0, 0,  -7, 3);
        tbl[7] = mk(1, 1,   0, -255, 100,  0, 255, 100, 1, 0, 0, 255, 6);

        rst = 1'b1; start = 1'b0; dir_ready = 1'b1; len_a = '0; len_b = '0;
        tick(); tick();
        rst = 1'b0;
        chk("rst_en_dout", int'(en_dout), 0);
        chk("rst_addr", int'(addr_dout), 0);
        chk("rst_dir_valid", int'(dir_valid), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_final", int'(final_score), 0);

        for (int i = 0; i < 8; i++) begin
            run_walk(tbl[i], 1'b0);
            check_walk(tbl[i], i);
            if (i == 1) begin
                chk("v1_addr0", (addr_log.size() > 0) ? addr_log[0] : -1, 10);
                chk("v1_addr1", (addr_log.size() > 1) ? addr_log[1] : -1, 5);
            end
        end
        tick();
        chk("final_held", int'(final_score), 255);

        // Backpressure on a single DIAG beat
        load_ram(tbl[2]);
        len_a = 3'd1; len_b = 3'd1; dir_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(ok);
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("bp_valid%0d", k), int'(dir_valid), 1);
            chk($sformatf("bp_dir%0d", k), int'(dir), 0);
            chk($sformatf("bp_last%0d", k), int'(dir_last), 1);
            chk($sformatf("bp_en%0d", k), int'(en_dout), 0);
            tick();
        end
        chk("bp_still_valid", int'(dir_valid), 1);
        dir_ready = 1'b1;
        tick();
        chk("bp_valid_dropped", int'(dir_valid), 0);
        chk("bp_done", int'(done), 1);
        tick();

        // Reset while a beat is stalled in EMIT
        load_ram(tbl[3]);
        len_a = 3'd1; len_b = 3'd1; dir_ready = 1'b0; start = 1'b1;
        tick();
        start = 1'b0;
        wait_valid(ok);
        chk("pre_rst_dir", int'(dir), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("mid_rst_en", int'(en_dout), 0);
        chk("mid_rst_addr", int'(addr_dout), 0);
        chk("mid_rst_dir", int'(dir), 0);
        chk("mid_rst_valid", int'(dir_valid), 0);
        chk("mid_rst_last", int'(dir_last), 0);
        chk("mid_rst_busy", int'(busy), 0);
        chk("mid_rst_done", int'(done), 0);
        chk("mid_rst_final", int'(final_score), 0);

        // Fresh walk after reset, with a start pulse that must be ignored
        run_walk(tbl[3], 1'b1);
        check_walk(tbl[3], 8);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
